// File: rtl/si5338_status_monitor.sv
// Periodically reads the SI5338 status register through the shared I2C reader
// handshake and debounces the fault bits into a single lock indication.
module si5338_status_monitor #(
    parameter logic [31:0] g_PollPeriod = 32'd1_000_000,
    parameter logic [7:0]  g_StatusReg  = 8'd218,
    parameter logic [7:0]  g_StatusMask = 8'h15,
    parameter logic [3:0]  g_LockCount  = 4'd4,
    parameter logic [31:0] g_RdyTimeout = 32'd100_000
) (
    input  logic        Clk,
    input  logic        Rstn,
    input  logic        ConfigDone_i,
    output logic        Rw_o,
    output logic [15:0] Data_o16b,
    output logic        Val_o,
    input  logic        Rdy_i,
    input  logic [7:0]  Data_i8b,
    output logic        Locked_o,
    output logic [7:0]  Status_ob8,
    output logic [15:0] LossCount_ob16,
    output logic        Timeout_o
);

    localparam logic [2:0] DISABLED    = 3'd0;
    localparam logic [2:0] WAIT_PERIOD = 3'd1;
    localparam logic [2:0] REQ         = 3'd2;
    localparam logic [2:0] BUSY        = 3'd3;
    localparam logic [2:0] EVAL        = 3'd4;

    logic [2:0]  state;
    logic [31:0] period_cnt;
    logic [31:0] phase_cnt;
    logic        seen_rdy;
    logic [3:0]  good_cnt;
    logic [7:0]  capt;

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state          <= DISABLED;
            period_cnt     <= '0;
            phase_cnt      <= '0;
            seen_rdy       <= 1'b0;
            good_cnt       <= '0;
            capt           <= '0;
            Rw_o           <= 1'b1;
            Data_o16b      <= {g_StatusReg, 8'h00};
            Val_o          <= 1'b0;
            Locked_o       <= 1'b0;
            Status_ob8     <= '0;
            LossCount_ob16 <= '0;
            Timeout_o      <= 1'b0;
        end else begin
            Rw_o      <= 1'b1;
            Data_o16b <= {g_StatusReg, 8'h00};
            case (state)
                DISABLED: begin
                    if (ConfigDone_i) begin
                        period_cnt <= g_PollPeriod - 32'd1;
                        state      <= WAIT_PERIOD;
                    end
                end
                WAIT_PERIOD: begin
                    if (!ConfigDone_i) begin
                        state    <= DISABLED;
                        Locked_o <= 1'b0;
                        good_cnt <= '0;
                    end else if (period_cnt == '0) begin
                        state     <= REQ;
                        Val_o     <= 1'b1;
                        phase_cnt <= '0;
                        seen_rdy  <= 1'b0;
                    end else begin
                        period_cnt <= period_cnt - 32'd1;
                    end
                end
                REQ: begin
                    // Acceptance is Rdy_i falling after it was seen high while Val_o was up
                    if (seen_rdy && !Rdy_i) begin
                        Val_o     <= 1'b0;
                        state     <= BUSY;
                        phase_cnt <= '0;
                    end else if (phase_cnt == g_RdyTimeout - 32'd1) begin
                        Timeout_o  <= 1'b1;
                        Val_o      <= 1'b0;
                        Locked_o   <= 1'b0;
                        good_cnt   <= '0;
                        period_cnt <= g_PollPeriod - 32'd1;
                        state      <= WAIT_PERIOD;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                        if (Rdy_i) seen_rdy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (Rdy_i) begin
                        capt  <= Data_i8b;
                        state <= EVAL;
                    end else if (phase_cnt == g_RdyTimeout - 32'd1) begin
                        Timeout_o  <= 1'b1;
                        Val_o      <= 1'b0;
                        Locked_o   <= 1'b0;
                        good_cnt   <= '0;
                        period_cnt <= g_PollPeriod - 32'd1;
                        state      <= WAIT_PERIOD;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end
                EVAL: begin
                    // A read finishing after the configurer dropped its enable is discarded
                    if (!ConfigDone_i) begin
                        state    <= DISABLED;
                        Locked_o <= 1'b0;
                        good_cnt <= '0;
                    end else begin
                        state      <= WAIT_PERIOD;
                        period_cnt <= g_PollPeriod - 32'd1;
                        Status_ob8 <= capt;
                        if ((capt & g_StatusMask) == 8'h00) begin
                            if (good_cnt < g_LockCount) good_cnt <= good_cnt + 4'd1;
                            if (good_cnt >= g_LockCount - 4'd1) Locked_o <= 1'b1;
                        end else begin
                            good_cnt <= '0;
                            if (Locked_o) begin
                                Locked_o <= 1'b0;
                                if (LossCount_ob16 != '1) LossCount_ob16 <= LossCount_ob16 + 16'd1;
                            end
                        end
                    end
                end
                default: state <= DISABLED;
            endcase
        end
    end

endmodule

// File: tb/tb_si5338_status_monitor.sv
// Directed bench for si5338_status_monitor; the bench plays the I2C reader role.
module tb_si5338_status_monitor;

    logic        Clk = 1'b0;
    logic        Rstn;
    logic        ConfigDone_i;
    logic        Rw_o;
    logic [15:0] Data_o16b;
    logic        Val_o;
    logic        Rdy_i;
    logic [7:0]  Data_i8b;
    logic        Locked_o;
    logic [7:0]  Status_ob8;
    logic [15:0] LossCount_ob16;
    logic        Timeout_o;

    int vectors = 0;
    int miscompares = 0;

    si5338_status_monitor #(
        .g_PollPeriod(32'd16),
        .g_StatusReg(8'd218),
        .g_StatusMask(8'h15),
        .g_LockCount(4'd4),
        .g_RdyTimeout(32'd50)
    ) dut (
        .Clk(Clk),
        .Rstn(Rstn),
        .ConfigDone_i(ConfigDone_i),
        .Rw_o(Rw_o),
        .Data_o16b(Data_o16b),
        .Val_o(Val_o),
        .Rdy_i(Rdy_i),
        .Data_i8b(Data_i8b),
        .Locked_o(Locked_o),
        .Status_ob8(Status_ob8),
        .LossCount_ob16(LossCount_ob16),
        .Timeout_o(Timeout_o)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until Val_o is seen high; bounded.
    task automatic wait_val(output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Val_o !== 1'b1 && n < 200);
        if (n >= 200) check("val_wait_expired", 32'(Val_o), 32'd1);
    endtask

    // One read transaction; returns Locked_o during EVAL and after it.
    task automatic serve(input logic [7:0] d, input bit drop_cfg,
                         output int wait_n, output logic lk_eval, output logic lk_after);
        wait_val(wait_n);
        @(negedge Clk);
        Rdy_i = 1'b0;
        @(negedge Clk);
        check("val_drop_after_accept", 32'(Val_o), 32'd0);
        if (drop_cfg) ConfigDone_i = 1'b0;
        @(negedge Clk);
        Rdy_i    = 1'b1;
        Data_i8b = d;
        @(negedge Clk);
        lk_eval = Locked_o;
        @(negedge Clk);
        lk_after = Locked_o;
    endtask

    initial begin
        int   wn;
        int   cnt;
        logic le;
        logic la;

        Rstn = 1'b0; ConfigDone_i = 1'b0; Rdy_i = 1'b1; Data_i8b = 8'h00;
        repeat (3) @(negedge Clk);
        check("rst_val", 32'(Val_o), 32'd0);
        check("rst_rw", 32'(Rw_o), 32'd1);
        check("rst_data16", 32'(Data_o16b), 32'hDA00);
        check("rst_locked", 32'(Locked_o), 32'd0);
        check("rst_status", 32'(Status_ob8), 32'd0);
        check("rst_loss", 32'(LossCount_ob16), 32'd0);
        check("rst_timeout", 32'(Timeout_o), 32'd0);

        Rstn = 1'b1;
        repeat (5) @(negedge Clk);
        check("disabled_no_val", 32'(Val_o), 32'd0);

        // Lock acquisition with clean reads
        ConfigDone_i = 1'b1;
        serve(8'h00, 1'b0, wn, le, la);
        check("first_val_latency", 32'(wn), 32'd17);
        check("read1_locked", 32'(la), 32'd0);
        serve(8'h00, 1'b0, wn, le, la);
        check("read2_locked", 32'(la), 32'd0);
        serve(8'h00, 1'b0, wn, le, la);
        check("read3_locked", 32'(la), 32'd0);
        serve(8'h00, 1'b0, wn, le, la);
        check("read4_locked_eval", 32'(le), 32'd0);
        check("read4_locked_after", 32'(la), 32'd1);
        check("status_clean", 32'(Status_ob8), 32'h00);
        check("data16", 32'(Data_o16b), 32'hDA00);

        // Loss of lock on one PLL_LOL read, then relock
        serve(8'h10, 1'b0, wn, le, la);
        check("lol_locked", 32'(la), 32'd0);
        check("lol_loss", 32'(LossCount_ob16), 32'd1);
        check("lol_status", 32'(Status_ob8), 32'h10);
        serve(8'h00, 1'b0, wn, le, la);
        serve(8'h00, 1'b0, wn, le, la);
        serve(8'h00, 1'b0, wn, le, la);
        check("relock3_locked", 32'(la), 32'd0);
        serve(8'h00, 1'b0, wn, le, la);
        check("relock4_locked", 32'(la), 32'd1);

        // Reader never accepts: timeout after 50 cycles of Val_o
        wait_val(wn);
        cnt = 1;
        @(negedge Clk);
        while (Val_o === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge Clk);
        end
        check("timeout_val_cycles", 32'(cnt), 32'd50);
        check("timeout_flag", 32'(Timeout_o), 32'd1);
        check("timeout_locked", 32'(Locked_o), 32'd0);
        check("timeout_loss_kept", 32'(LossCount_ob16), 32'd1);

        // Unmasked LOS_FDBK bit counts as clean
        serve(8'h08, 1'b0, wn, le, la);
        check("post_timeout_spacing", 32'(wn), 32'd16);
        serve(8'h08, 1'b0, wn, le, la);
        serve(8'h08, 1'b0, wn, le, la);
        check("fdbk3_locked", 32'(la), 32'd0);
        serve(8'h08, 1'b0, wn, le, la);
        check("fdbk4_locked", 32'(la), 32'd1);
        check("fdbk_status", 32'(Status_ob8), 32'h08);
        check("timeout_sticky", 32'(Timeout_o), 32'd1);

        // Enable drops during BUSY: result discarded, block disables
        serve(8'h04, 1'b1, wn, le, la);
        check("cfgdrop_locked", 32'(la), 32'd0);
        check("cfgdrop_status", 32'(Status_ob8), 32'h08);
        check("cfgdrop_loss", 32'(LossCount_ob16), 32'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Val_o === 1'b1) cnt++;
        end
        check("cfgdrop_no_val", 32'(cnt), 32'd0);

        ConfigDone_i = 1'b1;
        serve(8'h00, 1'b0, wn, le, la);
        check("restart_latency", 32'(wn), 32'd17);
        check("restart1_locked", 32'(la), 32'd0);
        serve(8'h00, 1'b0, wn, le, la);
        serve(8'h00, 1'b0, wn, le, la);
        check("restart3_locked", 32'(la), 32'd0);
        serve(8'h00, 1'b0, wn, le, la);
        check("restart4_locked", 32'(la), 32'd1);

        // Asynchronous reset while a request is pending
        wait_val(wn);
        Rstn = 1'b0;
        #1;
        check("arst_val", 32'(Val_o), 32'd0);
        check("arst_locked", 32'(Locked_o), 32'd0);
        check("arst_loss", 32'(LossCount_ob16), 32'd0);
        check("arst_timeout", 32'(Timeout_o), 32'd0);
        check("arst_status", 32'(Status_ob8), 32'd0);
        @(negedge Clk);
        Rstn = 1'b1;
        wait_val(wn);
        check("arst_restart_latency", 32'(wn), 32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/si5338_status_monitor.md
# si5338_status_monitor

Polls the SI5338 status register (218) after the clock-generator configuration finishes, and debounces the loss-of-signal and loss-of-lock flags into a single `Locked_o` indication. It sits beside `si5338_configurer` as the second client of the I2C register reader. It uses the same request handshake (`Rw`/`Data16`/`Val`/`Rdy`/`Data8`) and takes its enable from the configurer's `Finished_o`. Its outputs feed the diagnostics status registers.

## Interface

Parameters:
- `g_PollPeriod`, 32'd1_000_000: idle cycles between consecutive status reads (≥2).
- `g_StatusReg`, 8'd218: register address polled.
- `g_StatusMask`, 8'h15: status bits that count as a fault. Bit 4 is PLL_LOL, bit 2 is LOS_CLKIN, bit 0 is SYS_CAL.
- `g_LockCount`, 4'd4: number of consecutive clean reads before `Locked_o` asserts (1..15).
- `g_RdyTimeout`, 32'd100_000: maximum cycles to wait in any handshake phase.

Ports:
- `Clk` in 1: system clock.
- `Rstn` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `ConfigDone_i` in 1: level, high while the SI5338 is configured.
- `Rw_o` out 1: request type; always 1 (read).
- `Data_o16b` out 16: `{g_StatusReg, 8'h00}`.
- `Val_o` out 1: request valid.
- `Rdy_i` in 1: reader idle/ready; low while a transaction runs.
- `Data_i8b` in 8: read data; valid on the cycle `Rdy_i` returns high.
- `Locked_o` out 1: debounced lock indication.
- `Status_ob8` out 8: last raw value read.
- `LossCount_ob16` out 16: count of locked→unlocked transitions; saturates at 16'hFFFF.
- `Timeout_o` out 1: sticky flag, set on any handshake timeout.

## Operation

- Reset values: `Val_o`=0, `Rw_o`=1, `Data_o16b`={g_StatusReg,8'h00}, `Locked_o`=0, `Status_ob8`=0, `LossCount_ob16`=0, `Timeout_o`=0. The state machine resets to DISABLED and the good-read counter to 0.
- DISABLED: stays here while `ConfigDone_i`=0. On `ConfigDone_i`=1 it loads the period counter and moves to WAIT_PERIOD.
- WAIT_PERIOD: counts `g_PollPeriod` cycles, then moves to REQ. If `ConfigDone_i`=0, it goes to DISABLED next cycle and clears `Locked_o` and the good-read counter.
- REQ: `Val_o`=1. Waits for `Rdy_i`=1, then for `Rdy_i` to fall while `Val_o`=1; that falling edge is the acceptance. On acceptance, `Val_o` drops next cycle and the block moves to BUSY.
- BUSY: waits for `Rdy_i`=1, captures `Data_i8b`, then moves to EVAL.
- EVAL (one cycle), with a read counted good when `(data & g_StatusMask)==0`:
  - `Status_ob8` takes the captured data.
  - Good read: the good-read counter increments, saturating at `g_LockCount`. `Locked_o` sets when the counter reaches `g_LockCount`.
  - Bad read: the good-read counter clears. If `Locked_o` was 1, `LossCount_ob16` increments (saturating) and `Locked_o` clears.
  - Next state: WAIT_PERIOD, or DISABLED if `ConfigDone_i`=0. When going to DISABLED the result is discarded: `Status_ob8` and the counters are not updated and `Locked_o` is cleared.
- Timeout: a per-phase counter runs in REQ and BUSY and resets on each state entry. When it reaches `g_RdyTimeout`:
  - `Timeout_o` is set and stays set until reset.
  - `Val_o`=0, `Locked_o`=0, good-read counter=0, `LossCount_ob16` unchanged.
  - Next state is WAIT_PERIOD.
- A `ConfigDone_i` fall during REQ or BUSY does not abort the transaction. The transaction completes (or times out) and the block then goes to DISABLED.
- All outputs are registered.

## Timing

- `Val_o` rises on the first cycle in REQ, which is the cycle after the period counter expires.
- From `ConfigDone_i` rising (cycle 0), the first `Val_o`=1 appears at cycle `g_PollPeriod`+1.
- Data captured on cycle N (`Rdy_i` high in BUSY) updates `Status_ob8`/`Locked_o` at N+2. EVAL takes one cycle and the outputs register at its end.
- `Val_o` never stays high more than one cycle after `Rdy_i` falls.
- Request spacing is `g_PollPeriod` + handshake time + 2.
- Asynchronous `Rstn` assertion mid-transaction drops `Val_o` immediately. After release, the first request waits a full poll period.

## Test plan

- Reset, then `ConfigDone_i`=1 with reader model returning 8'h00 (g_PollPeriod=16, g_LockCount=4):
  - `Locked_o` stays 0 after read 3 and rises 2 cycles after read 4's data.
  - `Status_ob8`=8'h00 and `Data_o16b`=16'hDA00.
- Locked state, reader returns 8'h10 (LOL) once then 8'h00:
  - `Locked_o` falls and `LossCount_ob16`=1.
  - `Locked_o` returns after 4 more clean reads.
- Reader returns 8'h08 (unmasked LOS_FDBK): each read counts as good and `Locked_o` asserts; `Status_ob8`=8'h08.
- Reader model never lowers `Rdy_i` after `Val_o` (g_RdyTimeout=50):
  - `Val_o` drops after 50 cycles and `Timeout_o`=1 (sticky).
  - The next request follows after one poll period.
- `ConfigDone_i` falls during BUSY:
  - The transaction finishes, then DISABLED; `Locked_o`=0 and no further `Val_o`.
  - Re-raising `ConfigDone_i` restarts polling from a cleared good-read counter.
- `Rstn` pulsed low while `Val_o`=1: all outputs return to reset values asynchronously, including `LossCount_ob16`=0 and `Timeout_o`=0.
